// File: rtl/zbritesi_serial_16bit.sv
// Bit-serial subtractor: DIFF = A - B - BIN, one bit per clock, LSB first, single borrow flop.
// Optional add mode (MODE input) enabled by defining ZBRITESI_ADD_MODE_EN.
module zbritesi_serial_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef ZBRITESI_ADD_MODE_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    // Handshake: start is sampled only in IDLE (accept edge); busy is high for the WIDTH
    // SHIFT cycles; done is a one-cycle pulse in FIN, when the result outputs are already valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sb, res, res_next;
    logic [CW-1:0]    cnt;
    logic             bor, bor_next, d, a_eff, last_bit, sub;

`ifdef ZBRITESI_ADD_MODE_EN
    logic sub_q;
    assign sub = sub_q;
`else
    assign sub = 1'b1;
`endif

    always_comb begin
        // Subtract borrow equals the add carry with the minuend bit inverted.
        a_eff    = sub ? ~sa[0] : sa[0];
        d        = sa[0] ^ sb[0] ^ bor;
        bor_next = (a_eff & sb[0]) | (a_eff & bor) | (sb[0] & bor);
        res_next = {d, res[WIDTH-1:1]};
        last_bit = (cnt == CNT_LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            bor  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
`ifdef ZBRITESI_ADD_MODE_EN
            sub_q <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        bor <= bin;
                        cnt <= '0;
`ifdef ZBRITESI_ADD_MODE_EN
                        sub_q <= mode;
`endif
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_next;
                    bor <= bor_next;
                    cnt <= cnt + 1'b1;
                    // On the MSB, bor still holds the borrow into the MSB.
                    if (last_bit) begin
                        diff <= res_next;
                        bout <= bor_next;
                        zero <= (res_next == '0);
                        ovf  <= bor ^ bor_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == FIN);
    assign state_dbg = state;

endmodule
